elevator_sequencer: RTL and testbench

Clocked controller that owns the elevator request queue and drives the cabin. It samples floor-button presses, appends new levels to a FIFO-ordered queue, moves the cabin one level at a time toward the queue head, and stops at any queued level it passes. On each stop it opens the door for a timed interval. It is the sequential wrapper around the combinational queue/stop logic and holds all cabin state.

---
 rtl/elevator_sequencer_if.sv | 26 ++
 rtl/elevator_sequencer.sv | 144 ++++++++++++++
 tb/tb_elevator_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_sequencer_if.sv
// Button/cabin bundle for elevator_sequencer; door_hold exists only when DOOR_HOLD_EN is defined.
interface elevator_sequencer_if #(parameter int DEPTH = 6);
  logic [3:0]         ipmod30;
`ifdef DOOR_HOLD_EN
  logic               door_hold;
`endif
  logic [1:0]         pos_lvl;
  logic [2*DEPTH-1:0] queue;
  logic [2:0]         tail;
  logic               door_open;
  logic               moving;
  logic               dir_up;
  logic               drop;

`ifdef DOOR_HOLD_EN
  modport master (output ipmod30, door_hold,
                  input  pos_lvl, queue, tail, door_open, moving, dir_up, drop);
  modport slave  (input  ipmod30, door_hold,
                  output pos_lvl, queue, tail, door_open, moving, dir_up, drop);
`else
  modport master (output ipmod30,
                  input  pos_lvl, queue, tail, door_open, moving, dir_up, drop);
  modport slave  (input  ipmod30,
                  output pos_lvl, queue, tail, door_open, moving, dir_up, drop);
`endif
endinterface

// File: rtl/elevator_sequencer.sv
// Elevator request queue + cabin FSM (IDLE/MOVING/DOOR_OPEN).
// Optional DOOR_HOLD_EN: door_hold freezes the door counter while the door is open.
module elevator_sequencer #(
  parameter int DEPTH       = 6,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  elevator_sequencer_if.slave  bus
);
  localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_e;
  typedef logic [DEPTH-1:0][1:0] queue_t;

  state_e        st_q, st_d;
  logic [1:0]    pos_q, pos_d;
  queue_t        q_q, q_d, q_rm;
  logic [2:0]    tail_q, tail_d, tail_rm;
  logic          dir_q, dir_d;
  logic [CW-1:0] mcnt_q, mcnt_d, dcnt_q, dcnt_d;

  logic             p_vld, step, stop, in_q, served, same_lvl, accept, full, hold;
  logic [1:0]       p, step_lvl;
  logic [DEPTH-1:0] shift;

`ifdef DOOR_HOLD_EN
  assign hold = bus.door_hold;
`else
  assign hold = 1'b0;
`endif

  // Lowest pressed button wins.
  always_comb begin
    p_vld = |bus.ipmod30;
    p     = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (bus.ipmod30[i]) p = 2'(i);
  end

  // Arrival removal is resolved before the press so appends see the post-removal tail.
  always_comb begin
    step     = (st_q == MOVING) && (mcnt_q == '0);
    step_lvl = dir_q ? pos_q + 2'd1 : pos_q - 2'd1;
    stop     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (step && (3'(i) < tail_q) && (q_q[i] == step_lvl)) stop = 1'b1;
      shift[i] = stop;
    end
    q_rm = q_q;
    for (int i = 0; i < DEPTH - 1; i++)
      if (shift[i]) q_rm[i] = q_q[i+1];
    if (stop) q_rm[DEPTH-1] = 2'd0;
    tail_rm = tail_q - 3'(stop);
  end

  always_comb begin
    in_q = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if ((3'(i) < tail_rm) && (q_rm[i] == p)) in_q = 1'b1;
    served   = stop && (p == step_lvl);
    same_lvl = p_vld && !in_q && (p == pos_q) && (st_q != MOVING);
    accept   = p_vld && !in_q && !served && !same_lvl;
    full     = (tail_rm == 3'(DEPTH));
    q_d      = q_rm;
    tail_d   = tail_rm;
    if (accept && !full) begin
      for (int i = 0; i < DEPTH; i++)
        if (3'(i) == tail_rm) q_d[i] = p;
      tail_d = tail_rm + 3'd1;
    end
  end

  always_comb begin
    st_d   = st_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    mcnt_d = mcnt_q;
    dcnt_d = dcnt_q;
    case (st_q)
      IDLE: begin
        if (same_lvl) begin
          st_d   = DOOR_OPEN;
          dcnt_d = CW'(DOOR_CYCLES - 1);
        end else if (tail_q != 3'd0) begin
          st_d   = MOVING;
          dir_d  = q_q[0] > pos_q;
          mcnt_d = CW'(MOVE_CYCLES - 1);
        end
      end
      MOVING: begin
        if (!step) begin
          mcnt_d = mcnt_q - CW'(1);
        end else begin
          pos_d = step_lvl;
          if (stop) begin
            st_d   = DOOR_OPEN;
            dcnt_d = CW'(DOOR_CYCLES - 1);
          end else begin
            dir_d  = q_q[0] > step_lvl;
            mcnt_d = CW'(MOVE_CYCLES - 1);
          end
        end
      end
      DOOR_OPEN: begin
        if (same_lvl)              dcnt_d = CW'(DOOR_CYCLES - 1);
        else if (hold)             dcnt_d = dcnt_q;
        else if (dcnt_q == '0)     st_d   = IDLE;
        else                       dcnt_d = dcnt_q - CW'(1);
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      pos_q  <= 2'd0;
      q_q    <= '0;
      tail_q <= 3'd0;
      dir_q  <= 1'b1;
      mcnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      pos_q  <= pos_d;
      q_q    <= q_d;
      tail_q <= tail_d;
      dir_q  <= dir_d;
      mcnt_q <= mcnt_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign bus.pos_lvl   = pos_q;
  assign bus.queue     = q_q;
  assign bus.tail      = tail_q;
  assign bus.door_open = (st_q == DOOR_OPEN);
  assign bus.moving    = (st_q == MOVING);
  assign bus.dir_up    = dir_q;
  assign bus.drop      = accept && full;
endmodule

// File: tb/tb_elevator_sequencer.sv
// Bench for elevator_sequencer: queue-based reference model, directed scenarios, random presses.
module tb_elevator_sequencer;
  localparam int DEPTH = 3;
  localparam int MOVE  = 4;
  localparam int DOOR  = 3;
  localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2;
`ifdef DOOR_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  elevator_sequencer_if #(.DEPTH(DEPTH)) bus ();
  elevator_sequencer #(.DEPTH(DEPTH), .MOVE_CYCLES(MOVE), .DOOR_CYCLES(DOOR))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: ordered list of pending levels plus cycles left in the current activity.
  int m_pos, m_mode, m_left;
  bit m_dir, m_drop;
  int mq[$];
  int n_chk, n_fail;
  bit last_drop;

  function automatic bit inq(input int v);
    foreach (mq[i]) if (mq[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_mode = M_IDLE; m_left = 0; m_dir = 1'b1; m_drop = 1'b0;
    mq.delete();
  endtask

  task automatic model_step(input logic [3:0] ip, input bit hold);
    int p, nl, k;
    bit have;
    have = (ip != 4'd0);
    p = 0;
    for (int i = 3; i >= 0; i--) if (ip[i]) p = i;
    m_drop = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (have && p == m_pos && !inq(p)) begin
          m_mode = M_DOOR; m_left = DOOR; have = 1'b0;
        end else if (mq.size() > 0) begin
          m_dir = (mq[0] > m_pos); m_mode = M_MOVE; m_left = MOVE;
        end
      end
      M_MOVE: begin
        m_left--;
        if (m_left == 0) begin
          nl = m_dir ? m_pos + 1 : m_pos - 1;
          m_pos = nl;
          k = -1;
          foreach (mq[i]) if (k < 0 && mq[i] == nl) k = i;
          if (k >= 0) begin
            mq.delete(k);
            m_mode = M_DOOR; m_left = DOOR;
            if (have && p == nl) have = 1'b0;
          end else begin
            if (mq.size() > 0) m_dir = (mq[0] > nl);
            m_left = MOVE;
          end
        end
      end
      default: begin
        if (have && p == m_pos && !inq(p)) begin
          m_left = DOOR; have = 1'b0;
        end else if (!hold) begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
    endcase
    if (have && !inq(p)) begin
      if (mq.size() < DEPTH) mq.push_back(p);
      else m_drop = 1'b1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_regs();
    int qexp;
    qexp = 0;
    foreach (mq[i]) qexp |= mq[i] << (2 * i);
    chk("pos_lvl",   int'(bus.pos_lvl),   m_pos);
    chk("queue",     int'(bus.queue),     qexp);
    chk("tail",      int'(bus.tail),      mq.size());
    chk("door_open", int'(bus.door_open), int'(m_mode == M_DOOR));
    chk("moving",    int'(bus.moving),    int'(m_mode == M_MOVE));
    chk("dir_up",    int'(bus.dir_up),    int'(m_dir));
  endtask

  // One clock: drive at negedge, check drop mid-cycle, check registers after the edge.
  task automatic cycle(input logic [3:0] ip, input bit hold = 1'b0);
    @(negedge clk);
    bus.ipmod30 = ip;
`ifdef DOOR_HOLD_EN
    bus.door_hold = hold;
`endif
    #1;
    model_step(ip, hold & HOLD_ON);
    last_drop = bus.drop;
    chk("drop", int'(bus.drop), int'(m_drop));
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic check_reset_lits(input string tag);
    chk({tag, "_pos"},   int'(bus.pos_lvl),   0);
    chk({tag, "_queue"}, int'(bus.queue),     0);
    chk({tag, "_tail"},  int'(bus.tail),      0);
    chk({tag, "_door"},  int'(bus.door_open), 0);
    chk({tag, "_move"},  int'(bus.moving),    0);
    chk({tag, "_dir"},   int'(bus.dir_up),    1);
    chk({tag, "_drop"},  int'(bus.drop),      0);
  endtask

  // Reset lands between edges so the outputs must clear without a clock.
  task automatic do_reset();
    bus.ipmod30 = 4'd0;
`ifdef DOOR_HOLD_EN
    bus.door_hold = 1'b0;
`endif
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_lits("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int door_cnt;
    logic [3:0] ip;
    bit hold;
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    bus.ipmod30 = 4'd0;
`ifdef DOOR_HOLD_EN
    bus.door_hold = 1'b0;
`endif
    model_reset();
    #3;
    check_reset_lits("init");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single trip to level 2.
    cycle(4'b0100);
    chk("t1_tail", int'(bus.tail), 1);
    chk("t1_queue", int'(bus.queue), 2);
    door_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      cycle(4'b0000);
      if (bus.door_open) door_cnt++;
      if (k == 1)  chk("t1_moving", int'(bus.moving), 1);
      if (k == 4)  chk("t1_pos_k4", int'(bus.pos_lvl), 0);
      if (k == 5)  chk("t1_pos_k5", int'(bus.pos_lvl), 1);
      if (k == 9)  begin
        chk("t1_pos_k9", int'(bus.pos_lvl), 2);
        chk("t1_door_k9", int'(bus.door_open), 1);
        chk("t1_tail_k9", int'(bus.tail), 0);
      end
      if (k == 12) chk("t1_idle_door", int'(bus.door_open), 0);
    end
    chk("t1_door_cycles", door_cnt, 3);

    // Same-level press on the last door cycle reloads the door.
    door_cnt = 0;
    cycle(4'b0100); if (bus.door_open) door_cnt++;
    cycle(4'b0000); if (bus.door_open) door_cnt++;
    cycle(4'b0000); if (bus.door_open) door_cnt++;
    cycle(4'b0100); if (bus.door_open) door_cnt++;
    for (int k = 0; k < 6; k++) begin
      cycle(4'b0000);
      if (bus.door_open) door_cnt++;
    end
    chk("reload_door_cycles", door_cnt, 6);

    // Intermediate stop at 1 on the way to 3.
    do_reset();
    cycle(4'b1000);
    cycle(4'b0000);
    cycle(4'b0010);
    cycle(4'b0000);
    cycle(4'b0000);
    cycle(4'b0000);
    chk("stop1_pos", int'(bus.pos_lvl), 1);
    chk("stop1_door", int'(bus.door_open), 1);
    chk("stop1_tail", int'(bus.tail), 1);
    chk("stop1_queue", int'(bus.queue), 3);
    for (int k = 0; k < 15; k++) cycle(4'b0000);
    chk("stop3_pos", int'(bus.pos_lvl), 3);
    chk("stop3_tail", int'(bus.tail), 0);

    // Multiple bits: lowest wins.
    do_reset();
    cycle(4'b1010);
    chk("multi_queue", int'(bus.queue), 1);
    chk("multi_tail", int'(bus.tail), 1);

    // Fill, duplicate, overflow, and removal-then-append in one cycle.
    do_reset();
    cycle(4'b0010);
    cycle(4'b0100);
    cycle(4'b1000);
    chk("fill_tail", int'(bus.tail), 3);
    cycle(4'b0100);
    chk("dup_drop", int'(last_drop), 0);
    chk("dup_tail", int'(bus.tail), 3);
    cycle(4'b0001);
    chk("full_drop", int'(last_drop), 1);
    chk("full_tail", int'(bus.tail), 3);
    cycle(4'b0001);
    chk("rmapp_drop", int'(last_drop), 0);
    chk("rmapp_tail", int'(bus.tail), 3);
    chk("rmapp_queue", int'(bus.queue), 14);
    chk("rmapp_pos", int'(bus.pos_lvl), 1);

    // Reset in the middle of a move.
    do_reset();
    cycle(4'b1000);
    cycle(4'b0000);
    cycle(4'b0000);
    chk("pre_rst_moving", int'(bus.moving), 1);
    do_reset();

`ifdef DOOR_HOLD_EN
    cycle(4'b0001);
    door_cnt = bus.door_open ? 1 : 0;
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0000, 1'b1);
      if (bus.door_open) door_cnt++;
    end
    for (int k = 0; k < 4; k++) begin
      cycle(4'b0000, 1'b0);
      if (bus.door_open) door_cnt++;
    end
    chk("hold_door_cycles", door_cnt, 8);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        ip   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        hold = ($urandom_range(0, 7) == 0);
        cycle(ip, hold);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
